m2v_loader: RTL and testbench

M2V_LOADER -- requirements
Module: m2v_loader

---
 rtl/m2v_pkg.sv | 19 +
 rtl/m2v_loader.sv | 144 ++++++++++++++
 tb/tb_m2v_loader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m2v_pkg.sv
// Shared defaults and state encoding for the matrix/vector stream loader.
`timescale 1ns/1ps
package m2v_pkg;

  function automatic int m2v_run_cycles(input int dim);
    return 2 * dim;
  endfunction

  localparam int M2V_DIMENSION  = 16;
  localparam int M2V_WIDTH      = 8;
  localparam int M2V_RUN_CYCLES = m2v_run_cycles(M2V_DIMENSION);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } m2v_state_t;

endpackage

// File: rtl/m2v_loader.sv
// Loads a DIMENSION x DIMENSION matrix plus a vector from a valid/ready stream,
// then holds en_o high for RUN_CYCLES to drive the systolic multiplier.
`timescale 1ns/1ps
module m2v_loader
  import m2v_pkg::*;
#(
  parameter int DIMENSION  = M2V_DIMENSION,
  parameter int WIDTH      = M2V_WIDTH,
  parameter int RUN_CYCLES = m2v_run_cycles(DIMENSION)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [WIDTH-1:0]                     in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DIMENSION*DIMENSION*WIDTH-1:0] m_flat,
  output logic [DIMENSION*WIDTH-1:0]           v_flat,
  output logic                                 en_o,
  output logic                                 busy,
  output logic                                 done
);

  localparam int N_MAT  = DIMENSION * DIMENSION;
  localparam int N_ELEM = N_MAT + DIMENSION;
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int CNT_W  = $clog2(RUN_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(RUN_CYCLES - 1);

  m2v_state_t       r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_en, w_en_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_ready, w_ready_next;
  logic             w_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_en    <= w_en_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_ready <= w_ready_next;
    end
  end

  // Every output is computed one cycle ahead so the registers reflect the state they accompany.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_en_next    = 1'b0;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    w_ready_next = 1'b0;
    w_wr         = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_ready_next = 1'b1;
        if (in_valid && r_ready) begin
          w_wr = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_next = ST_RUN;
            w_idx_next   = '0;
            w_en_next    = 1'b1;
            w_busy_next  = 1'b1;
            w_ready_next = 1'b0;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      ST_RUN: begin
        w_busy_next = 1'b1;
        if (r_cnt == LAST_RUN) begin
          w_state_next = ST_DONE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
          w_en_next  = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_LOAD;
        w_ready_next = 1'b1;
      end
      default: begin
        w_state_next = ST_LOAD;
        w_ready_next = 1'b1;
      end
    endcase
    // Abort keeps buffer contents but drops any element offered in the same cycle.
    if (flush) begin
      w_state_next = ST_LOAD;
      w_idx_next   = '0;
      w_cnt_next   = '0;
      w_en_next    = 1'b0;
      w_busy_next  = 1'b0;
      w_done_next  = 1'b0;
      w_ready_next = 1'b1;
      w_wr         = 1'b0;
    end
  end

  // One register per element slot; slots below N_MAT form the matrix, the rest the vector.
  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_slot
      logic [WIDTH-1:0] r_slot;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_slot <= '0;
        end else if (w_wr && (r_idx == IDX_W'(gi))) begin
          r_slot <= in_data;
        end
      end
      if (gi < N_MAT) begin : g_mat
        assign m_flat[gi*WIDTH +: WIDTH] = r_slot;
      end else begin : g_vec
        assign v_flat[(gi-N_MAT)*WIDTH +: WIDTH] = r_slot;
      end
    end
  endgenerate

  assign in_ready = r_ready;
  assign en_o     = r_en;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_m2v_loader.sv
// Scoreboard bench for m2v_loader: streamed elements are queued and checked once the run starts.
`timescale 1ns/1ps
module tb_m2v_loader;
  import m2v_pkg::*;

  localparam int D  = 16;
  localparam int W  = 8;
  localparam int NM = D * D;
  localparam int NE = NM + D;
  localparam int RC = 2 * D;

  logic               clk = 1'b0;
  logic               rst, flush, in_valid, in_ready, en_o, busy, done;
  logic [W-1:0]       in_data;
  logic [D*D*W-1:0]   m_flat;
  logic [D*W-1:0]     v_flat;

  m2v_loader #(.DIMENSION(D), .WIDTH(W), .RUN_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .m_flat(m_flat), .v_flat(v_flat), .en_o(en_o),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observers updated on the falling edge only.
  int   burst_cnt = 0, cur_len = 0, last_len = 0, done_cnt = 0, acc_cnt = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (en_o === 1'b1 && prev_en !== 1'b1) begin
      burst_cnt = burst_cnt + 1;
      cur_len = 1;
    end else if (en_o === 1'b1) begin
      cur_len = cur_len + 1;
    end
    if (en_o !== 1'b1 && prev_en === 1'b1) last_len = cur_len;
    prev_en = en_o;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (in_valid === 1'b1 && in_ready === 1'b1) acc_cnt = acc_cnt + 1;
  end

  logic [W-1:0] exp_q[$];
  int t_start, t_last;
  bit aborted = 1'b0;

  function automatic logic [W-1:0] elem_val(input int kind, input int i);
    logic [7:0] b;
    b = i[7:0];
    case (kind)
      0:       return b;
      1:       return 8'hAA;
      default: return b ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [W-1:0] get_elem(input int i);
    if (i < NM) return m_flat[i*W +: W];
    return v_flat[(i-NM)*W +: W];
  endfunction

  task automatic send_elem(input logic [W-1:0] d, input bit gap);
    int budget;
    if (aborted) return;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    budget   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1) begin
      budget++;
      if (budget > 60) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
        aborted  = 1'b1;
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic stream_job(input int kind, input bit gaps, input int n);
    t_start = cyc;
    for (int i = 0; i < n; i++) send_elem(elem_val(kind, i), gaps);
    t_last = cyc;
  endtask

  task automatic wait_done();
    int budget = 0;
    @(negedge clk);
    while (done !== 1'b1) begin
      budget++;
      if (budget > 200) begin
        n_cmp++; n_err++;
        $display("FAIL done_timeout: done=%b required=1", done);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (en_o !== 1'b0)     begin n_err++; $display("FAIL rst_en_o: got %b required 0", en_o); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL rst_done: got %b required 0", done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (m_flat !== '0)     begin n_err++; $display("FAIL rst_m_flat: got nonzero required 0"); end
    n_cmp++; if (v_flat !== '0)     begin n_err++; $display("FAIL rst_v_flat: got %h required 0", v_flat); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_full_job();
    int b_burst, b_done, i;
    logic [W-1:0] e;
    b_burst = burst_cnt; b_done = done_cnt;
    @(posedge clk); #1;
    stream_job(0, 1'b0, NE);
    n_cmp++; if (t_last - t_start != NE) begin n_err++; $display("FAIL full_load_cycles: got %0d required %0d", t_last - t_start, NE); end
    @(negedge clk);
    n_cmp++; if (en_o !== 1'b1)     begin n_err++; $display("FAIL full_en_latency: got %b required 1", en_o); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_run: got %b required 0", in_ready); end
    n_cmp++; if (get_elem(3*D+5) !== 8'h35) begin n_err++; $display("FAIL full_m_r3e5: got %h required 35", get_elem(3*D+5)); end
    n_cmp++; if (v_flat[0 +: W] !== 8'h00)  begin n_err++; $display("FAIL full_v0: got %h required 00", v_flat[0 +: W]); end
    n_cmp++; if (v_flat[15*W +: W] !== 8'h0F) begin n_err++; $display("FAIL full_v15: got %h required 0f", v_flat[15*W +: W]); end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (get_elem(i) !== e) begin n_err++; $display("FAIL full_elem[%0d]: got %h required %h", i, get_elem(i), e); end
      i++;
    end
    wait_done();
    n_cmp++; if (en_o !== 1'b0) begin n_err++; $display("FAIL full_en_in_done: got %b required 0", en_o); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL full_done_width: got %b required 0", done); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after: got %b required 1", in_ready); end
    n_cmp++; if (last_len != RC)    begin n_err++; $display("FAIL full_burst_len: got %0d required %0d", last_len, RC); end
    n_cmp++; if (burst_cnt - b_burst != 1) begin n_err++; $display("FAIL full_bursts: got %0d required 1", burst_cnt - b_burst); end
    n_cmp++; if (done_cnt - b_done != 1)   begin n_err++; $display("FAIL full_done_pulses: got %0d required 1", done_cnt - b_done); end
    $display("test_full_job done");
  endtask

  task automatic test_backpressure();
    int i;
    logic [W-1:0] e;
    @(posedge clk); #1;
    stream_job(0, 1'b1, NE);
    n_cmp++; if (t_last - t_start != 2*NE) begin n_err++; $display("FAIL bp_load_cycles: got %0d required %0d", t_last - t_start, 2*NE); end
    @(negedge clk);
    n_cmp++; if (en_o !== 1'b1) begin n_err++; $display("FAIL bp_en_latency: got %b required 1", en_o); end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (get_elem(i) !== e) begin n_err++; $display("FAIL bp_elem[%0d]: got %h required %h", i, get_elem(i), e); end
      i++;
    end
    wait_done();
    @(negedge clk);
    n_cmp++; if (last_len != RC) begin n_err++; $display("FAIL bp_burst_len: got %0d required %0d", last_len, RC); end
    $display("test_backpressure done");
  endtask

  task automatic test_stream_during_run();
    int i, b_acc, budget;
    bit ready_seen;
    logic [W-1:0] e;
    @(posedge clk); #1;
    stream_job(2, 1'b0, NE);
    b_acc = acc_cnt;
    in_valid = 1'b1; in_data = 8'hFF;
    ready_seen = 1'b0; budget = 0;
    @(negedge clk);
    while (done !== 1'b1 && budget < 200) begin
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      budget++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (done !== 1'b1)    begin n_err++; $display("FAIL run_stream_done: got %b required 1", done); end
    n_cmp++; if (ready_seen != 1'b0) begin n_err++; $display("FAIL run_stream_ready: got 1 during run required 0"); end
    @(negedge clk);
    n_cmp++; if (acc_cnt - b_acc != 0) begin n_err++; $display("FAIL run_stream_consumed: got %0d required 0", acc_cnt - b_acc); end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (get_elem(i) !== e) begin n_err++; $display("FAIL run_stream_elem[%0d]: got %h required %h", i, get_elem(i), e); end
      i++;
    end
    $display("test_stream_during_run done");
  endtask

  task automatic test_flush();
    int b_burst, i;
    logic [W-1:0] e;
    @(posedge clk); #1;
    b_burst = burst_cnt;
    stream_job(0, 1'b0, 100);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_cmp++; if (en_o !== 1'b0)     begin n_err++; $display("FAIL flush_en: got %b required 0", en_o); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b required 1", in_ready); end
    n_cmp++; if (get_elem(100) !== elem_val(2, 100)) begin n_err++; $display("FAIL flush_offered_write: got %h required %h", get_elem(100), elem_val(2, 100)); end
    n_cmp++; if (get_elem(99) !== elem_val(0, 99))   begin n_err++; $display("FAIL flush_kept: got %h required %h", get_elem(99), elem_val(0, 99)); end
    @(posedge clk); #1;
    stream_job(1, 1'b0, NE);
    @(negedge clk);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (get_elem(i) !== e) begin n_err++; $display("FAIL flush_elem[%0d]: got %h required %h", i, get_elem(i), e); end
      i++;
    end
    wait_done();
    @(negedge clk);
    n_cmp++; if (burst_cnt - b_burst != 1) begin n_err++; $display("FAIL flush_bursts: got %0d required 1", burst_cnt - b_burst); end
    n_cmp++; if (last_len != RC) begin n_err++; $display("FAIL flush_burst_len: got %0d required %0d", last_len, RC); end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid_run();
    int b_done;
    bit en_seen;
    @(posedge clk); #1;
    b_done = done_cnt;
    stream_job(0, 1'b0, NE);
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (en_o !== 1'b0)  begin n_err++; $display("FAIL rstrun_en: got %b required 0", en_o); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rstrun_busy: got %b required 0", busy); end
    n_cmp++; if (m_flat !== '0)  begin n_err++; $display("FAIL rstrun_m_flat: got nonzero required 0"); end
    n_cmp++; if (v_flat !== '0)  begin n_err++; $display("FAIL rstrun_v_flat: got %h required 0", v_flat); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstrun_ready: got %b required 1", in_ready); end
    n_cmp++; if (last_len != 11)    begin n_err++; $display("FAIL rstrun_burst_len: got %0d required 11", last_len); end
    en_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (en_o !== 1'b0) en_seen = 1'b1;
    end
    n_cmp++; if (en_seen != 1'b0)       begin n_err++; $display("FAIL rstrun_en_after: got 1 required 0"); end
    n_cmp++; if (done_cnt != b_done)    begin n_err++; $display("FAIL rstrun_done: got %0d pulses required 0", done_cnt - b_done); end
    $display("test_reset_mid_run done");
  endtask

  task automatic test_back_to_back();
    int b_burst, d_cyc, i;
    logic [W-1:0] e;
    @(posedge clk); #1;
    b_burst = burst_cnt;
    stream_job(0, 1'b0, NE);
    exp_q.delete();
    wait_done();
    d_cyc = cyc;
    stream_job(2, 1'b0, NE);
    n_cmp++; if (t_last - d_cyc != NE + 1) begin n_err++; $display("FAIL b2b_first_accept: got %0d cycles required %0d", t_last - d_cyc, NE + 1); end
    @(negedge clk);
    n_cmp++; if (en_o !== 1'b1) begin n_err++; $display("FAIL b2b_en_rise: got %b required 1", en_o); end
    n_cmp++; if (cyc - d_cyc != NE + 1) begin n_err++; $display("FAIL b2b_gap: got %0d required %0d", cyc - d_cyc, NE + 1); end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++; if (get_elem(i) !== e) begin n_err++; $display("FAIL b2b_elem[%0d]: got %h required %h", i, get_elem(i), e); end
      i++;
    end
    wait_done();
    @(negedge clk);
    n_cmp++; if (burst_cnt - b_burst != 2) begin n_err++; $display("FAIL b2b_bursts: got %0d required 2", burst_cnt - b_burst); end
    n_cmp++; if (last_len != RC) begin n_err++; $display("FAIL b2b_burst_len: got %0d required %0d", last_len, RC); end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_backpressure();
    test_stream_during_run();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
